// File: rtl/mux_tree_pipe.sv
// N:1 word multiplexer built as a binary tree of 2:1 stages with an optional
// register after each tree level and valid/ready handshakes on both sides.
module mux_tree_pipe #(
  parameter int               DATA_W    = 8,
  parameter int               SEL_W     = 3,
  parameter logic [SEL_W-1:0] PIPE_MASK = {SEL_W{1'b1}}
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [(1<<SEL_W)*DATA_W-1:0]  in_data,
  input  logic [SEL_W-1:0]              in_sel,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data
);

  localparam int N = 1 << SEL_W;

  // Level boundary b carries N>>b words and the SEL_W-b select bits still needed.
  function automatic int doff(input int b);
    return (2*N - 2*(N >> b)) * DATA_W;
  endfunction

  function automatic int soff(input int b);
    return b*SEL_W - (b*(b-1))/2;
  endfunction

  wire [(2*N-1)*DATA_W-1:0]      dbus;
  wire [SEL_W*(SEL_W+1)/2-1:0]   sbus;
  wire [SEL_W:0]                 vbus;
  logic                          advance;

  assign dbus[0 +: N*DATA_W] = in_data;
  assign sbus[0 +: SEL_W]    = in_sel;
  assign vbus[0]             = in_valid;

  for (genvar k = 0; k < SEL_W; k++) begin : g_lvl
    localparam int WO  = (N >> (k+1)) * DATA_W;
    localparam int SI  = SEL_W - k;
    localparam int DI  = doff(k);
    localparam int DO  = doff(k+1);
    localparam int SIO = soff(k);
    localparam int SOO = soff(k+1);

    wire [WO-1:0] d_mux;

    for (genvar m = 0; m < (N >> (k+1)); m++) begin : g_pair
      assign d_mux[m*DATA_W +: DATA_W] = sbus[SIO] ? dbus[DI + (2*m+1)*DATA_W +: DATA_W]
                                                   : dbus[DI + (2*m)*DATA_W   +: DATA_W];
    end

    if (PIPE_MASK[k]) begin : g_reg
      logic [WO-1:0] d_q;
      logic          v_q;

      // Data loads on every advance regardless of valid; flush only kills valid.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          d_q <= '0;
          v_q <= 1'b0;
        end else begin
          if (flush)        v_q <= 1'b0;
          else if (advance) v_q <= vbus[k];
          if (advance)      d_q <= d_mux;
        end
      end

      assign dbus[DO +: WO] = d_q;
      assign vbus[k+1]      = v_q;

      if (SI > 1) begin : g_sel
        logic [SI-2:0] s_q;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)       s_q <= '0;
          else if (advance) s_q <= sbus[SIO+1 +: SI-1];
        end

        assign sbus[SOO +: SI-1] = s_q;
      end
    end else begin : g_wire
      assign dbus[DO +: WO] = d_mux;
      assign vbus[k+1]      = vbus[k];

      if (SI > 1) begin : g_sel
        assign sbus[SOO +: SI-1] = sbus[SIO+1 +: SI-1];
      end
    end
  end

  if (PIPE_MASK == '0) begin : g_comb
    assign advance   = out_ready;
    assign out_valid = vbus[SEL_W] & ~flush;
  end else begin : g_seq
    assign advance   = out_ready | ~out_valid;
    assign out_valid = vbus[SEL_W];
  end

  assign in_ready = advance;
  assign out_data = dbus[doff(SEL_W) +: DATA_W];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed bench for mux_tree_pipe: fully pipelined, partially pipelined and
// purely combinational instances driven from one clock.
module tb_mux_tree_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // fully registered, L=3
  logic        a_flush = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
  logic [63:0] a_in_data = '0;
  logic [2:0]  a_in_sel = '0;
  logic [7:0]  a_out_data;

  // middle level registered only, L=1
  logic        b_flush = 0, b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0;
  logic [63:0] b_in_data = '0;
  logic [2:0]  b_in_sel = '0;
  logic [7:0]  b_out_data;

  // combinational, 16 words of 16 bits
  logic         c_flush = 0, c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0;
  logic [255:0] c_in_data = '0;
  logic [3:0]   c_in_sel = '0;
  logic [15:0]  c_out_data;

  mux_tree_pipe #(.DATA_W(8), .SEL_W(3), .PIPE_MASK(3'b111)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_sel(a_in_sel), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data));

  mux_tree_pipe #(.DATA_W(8), .SEL_W(3), .PIPE_MASK(3'b010)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_sel(b_in_sel), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data));

  mux_tree_pipe #(.DATA_W(16), .SEL_W(4), .PIPE_MASK(4'b0000)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_sel(c_in_sel), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Eight transactions in_sel=0..7 on u_a with out_ready low for cycles st_lo..st_hi.
  task automatic run_stream(input int st_lo, input int st_hi, input int exp_last);
    int sent = 0, rcv = 0, first_acc = -1, first_out = -1, last_out = -1;
    logic acc;
    for (int c = 0; c < 40 && rcv < 8; c++) begin
      a_out_ready = !(c >= st_lo && c <= st_hi);
      a_in_valid  = (sent < 8);
      a_in_sel    = 3'(sent);
      @(negedge clk);
      acc = a_in_valid && a_in_ready;
      if (acc && first_acc < 0) first_acc = c;
      if (c >= st_lo && c <= st_hi) begin
        check("stall_in_ready", a_in_ready, 0);
        check("stall_out_valid", a_out_valid, 1);
        check("stall_hold_data", a_out_data, 8'hA0 + 8'(rcv));
      end else begin
        check("flow_in_ready", a_in_ready, 1);
      end
      if (a_out_valid && a_out_ready) begin
        check("stream_data", a_out_data, 8'hA0 + 8'(rcv));
        if (rcv == 0) first_out = c;
        last_out = c;
        rcv++;
      end
      @(posedge clk); #1;
      if (acc) sent++;
    end
    a_in_valid  = 0;
    a_out_ready = 1;
    check("stream_count", rcv, 8);
    check("first_latency", first_out - first_acc, 3);
    check("last_out_cycle", last_out, exp_last);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_dup", a_out_valid, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n;
    logic [7:0] e;
    int ps;

    for (int j = 0; j < 8; j++) a_in_data[j*8 +: 8] = 8'hA0 + 8'(j);

    // reset values while held in reset
    #1;
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_data", a_out_data, 8'h00);
    check("rst_in_ready", a_in_ready, 1);
    check("rst_b_out_valid", b_out_valid, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    // back-to-back sweep, then the same stream with a 4-cycle stall
    run_stream(100, 99, 10);
    run_stream(5, 8, 14);

    // flush with a full pipe: fill 3 while out_ready is low
    a_out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1; a_in_sel = 3'(i);
      @(negedge clk);
      check("fill_in_ready", a_in_ready, 1);
      @(posedge clk); #1;
    end
    a_flush = 1; a_in_valid = 1; a_in_sel = 3'd7; a_out_ready = 1;
    @(negedge clk);
    check("flush_full", a_out_valid, 1);
    check("flush_in_ready", a_in_ready, 1);
    @(posedge clk); #1;
    a_flush = 0; a_in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_flush_empty", a_out_valid, 0);
      @(posedge clk); #1;
    end
    a_in_data[23:16] = 8'h5C;
    a_in_valid = 1; a_in_sel = 3'd2;
    @(negedge clk);
    check("after_flush_accept", a_in_ready, 1);
    @(posedge clk); #1;
    a_in_valid = 0;
    n = 11;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (a_out_valid) begin n = i; break; end
    end
    check("after_flush_latency", n, 3);
    check("after_flush_data", a_out_data, 8'h5C);
    @(posedge clk); #1;

    // reset with two transactions in flight
    a_in_valid = 1; a_in_sel = 3'd4;
    @(posedge clk); #1;
    a_in_sel = 3'd5;
    @(posedge clk); #1;
    a_in_valid = 0; a_out_ready = 0;
    #2 rst_n = 0;
    #1;
    check("midrst_out_valid", a_out_valid, 0);
    check("midrst_out_data", a_out_data, 8'h00);
    check("midrst_in_ready", a_in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1; a_out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_no_stale", a_out_valid, 0);
      @(posedge clk); #1;
    end

    // L=1: select alternates 5/2 so every select bit flips each cycle
    b_out_ready = 1; b_in_valid = 1; ps = 0;
    for (int c = 0; c < 9; c++) begin
      b_in_sel = (c % 2 == 1) ? 3'd2 : 3'd5;
      for (int j = 0; j < 8; j++) b_in_data[j*8 +: 8] = 8'(c*13 + j*17);
      @(negedge clk);
      if (c > 0) begin
        e = 8'((c-1)*13 + ps*17);
        check("l1_valid", b_out_valid, 1);
        check("l1_data", b_out_data, e);
      end
      ps = int'(b_in_sel);
      @(posedge clk); #1;
    end
    b_in_valid = 0;

    // combinational mode
    for (int c = 0; c < 1000; c++) begin
      for (int w = 0; w < 16; w++) c_in_data[w*16 +: 16] = 16'($urandom);
      c_in_sel    = 4'($urandom_range(0, 15));
      c_in_valid  = 1'($urandom_range(0, 1));
      c_out_ready = 1'($urandom_range(0, 1));
      c_flush     = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      check("comb_data", c_out_data, c_in_data[c_in_sel*16 +: 16]);
      check("comb_valid", c_out_valid, c_in_valid & ~c_flush);
      check("comb_ready", c_in_ready, c_out_ready);
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
